// File: rtl/fx_alu_stream_pkg.sv
// Shared opcodes, FSM encoding and fixed-point helpers for the streaming fixed-point ALU.
package fx_alu_pkg;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_MAC  = 2;
  localparam int OP_CLR  = 3;
  localparam int OP_GRAY = 4;
  localparam int OP_CLZ  = 5;
  localparam int OP_ROR  = 6;
  localparam int OP_MAT  = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_OUT,
    ST_MOUT
  } state_t;

  // Values are carried at 64 bits so one helper serves every width up to 63.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] value,
                                                      input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  function automatic logic signed [63:0] round_half_up(input logic signed [63:0] value,
                                                       input int shift);
    return (value + (64'sd1 <<< (shift - 1))) >>> shift;
  endfunction

endpackage

// File: rtl/fx_alu_stream_if.sv
// Input handshake and result strobe bundle of the streaming fixed-point ALU.
interface fx_alu_stream_if #(
  parameter int INST_W = 4,
  parameter int DATA_W = 16
);
  logic                     i_in_valid;
  logic                     o_busy;
  logic [INST_W-1:0]        i_inst;
  logic signed [DATA_W-1:0] i_data_a;
  logic signed [DATA_W-1:0] i_data_b;
  logic                     o_out_valid;
  logic [DATA_W-1:0]        o_data;

  modport master (output i_in_valid, i_inst, i_data_a, i_data_b,
                  input  o_busy, o_out_valid, o_data);
  modport slave  (input  i_in_valid, i_inst, i_data_a, i_data_b,
                  output o_busy, o_out_valid, o_data);
endinterface

// File: rtl/fx_alu_stream_transpose.sv
// MAT_N x MAT_N element buffer: rows are written in order, columns are read out in order.
module fx_mat_transpose
  import fx_alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MAT_N  = 4,
  parameter int ELEM_W = DATA_W / MAT_N,
  localparam int WR_W  = $clog2(MAT_N),
  localparam int RD_W  = $clog2(MAT_N + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] row_i,
  input  logic              clr_i,
  input  logic              rd_en_i,
  output logic [WR_W-1:0]   row_cnt_o,
  output logic [DATA_W-1:0] col_o,
  output logic              last_o
);

  logic [WR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [RD_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ELEM_W-1:0] elem_q [MAT_N][MAT_N];
  logic [WR_W-1:0]   rd_idx;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en_i) wr_ptr_d = (wr_ptr_q == WR_W'(MAT_N - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Column 0 of a row sits in its most significant element.
  always_ff @(posedge i_clk) begin
    if (wr_en_i) begin
      for (int c = 0; c < MAT_N; c++) elem_q[wr_ptr_q][c] <= row_i[DATA_W-1-c*ELEM_W -: ELEM_W];
    end
  end

  assign rd_idx = rd_ptr_q[WR_W-1:0];

  always_comb begin
    col_o = '0;
    for (int r = 0; r < MAT_N; r++) col_o[DATA_W-1-r*ELEM_W -: ELEM_W] = elem_q[r][rd_idx];
  end

  assign row_cnt_o = wr_ptr_q;
  assign last_o    = (rd_ptr_q == RD_W'(MAT_N));

endmodule

// File: rtl/fx_alu_stream.sv
// Fixed-point ALU: scalar ops with 2-cycle latency, saturating MAC, and a streamed matrix transpose.
module fx_alu_stream
  import fx_alu_pkg::*;
#(
  parameter int INST_W  = 4,
  parameter int INT_W   = 6,
  parameter int FRAC_W  = 10,
  parameter int DATA_W  = INT_W + FRAC_W,
  parameter int GUARD_W = 4,
  parameter int MAT_N   = 4,
  parameter int ELEM_W  = DATA_W / MAT_N
) (
  input logic            i_clk,
  input logic            i_rst_n,
  fx_alu_stream_if.slave bus
);

  localparam int ACC_W = 2 * DATA_W + GUARD_W;
  localparam int SH_W  = $clog2(DATA_W);
  localparam int WR_W  = $clog2(MAT_N);

  state_t                   state_q, state_d;
  logic [INST_W-1:0]        op_q;
  logic signed [DATA_W-1:0] a_q, b_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        data_q, data_d;

  logic busy, accept, in_mat;
  logic wr_en, clr, rd_en, mat_last;
  logic [WR_W-1:0]          row_cnt;
  logic [DATA_W-1:0]        col_w, a_u, clz_w;
  logic [2*DATA_W-1:0]      ror_dbl;
  logic signed [63:0]       a_w, b_w, acc_sum_w, acc_sat_w;

  assign busy   = (state_q == ST_EXEC) || (state_q == ST_OUT) || (state_q == ST_MOUT);
  assign accept = bus.i_in_valid && !busy;
  assign in_mat = (bus.i_inst == INST_W'(OP_MAT));

  assign bus.o_busy      = busy;
  assign bus.o_out_valid = (state_q == ST_OUT) || (state_q == ST_MOUT);
  assign bus.o_data      = data_q;

  always_ff @(posedge i_clk) begin
    if (accept) begin
      op_q <= bus.i_inst;
      a_q  <= bus.i_data_a;
      b_q  <= bus.i_data_b;
    end
  end

  assign a_w       = 64'(a_q);
  assign b_w       = 64'(b_q);
  assign acc_sum_w = 64'(acc_q) + a_w * b_w;
  assign acc_sat_w = sat_to_width(acc_sum_w, ACC_W);
  assign a_u       = a_q;
  assign ror_dbl   = {a_u, a_u} >> b_q[SH_W-1:0];

  // Highest set bit is visited last, so it determines the count.
  always_comb begin
    clz_w = DATA_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) if (a_u[i]) clz_w = DATA_W'(DATA_W - 1 - i);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    acc_d   = acc_q;
    wr_en   = 1'b0;
    clr     = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (state_q == ST_IDLE) state_d = ST_LOAD;
        if (accept) begin
          if (in_mat) begin
            wr_en = 1'b1;
            if (row_cnt == WR_W'(MAT_N - 1)) state_d = ST_EXEC;
          end else begin
            clr     = (row_cnt != '0);
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        state_d = ST_OUT;
        case (op_q)
          INST_W'(OP_ADD):  data_d = DATA_W'(sat_to_width(a_w + b_w, DATA_W));
          INST_W'(OP_SUB):  data_d = DATA_W'(sat_to_width(a_w - b_w, DATA_W));
          INST_W'(OP_MAC): begin
            acc_d  = ACC_W'(acc_sat_w);
            data_d = DATA_W'(sat_to_width(round_half_up(acc_sat_w, FRAC_W), DATA_W));
          end
          INST_W'(OP_CLR): begin
            acc_d  = '0;
            data_d = '0;
          end
          INST_W'(OP_GRAY): data_d = a_u ^ (a_u >> 1);
          INST_W'(OP_CLZ):  data_d = clz_w;
          INST_W'(OP_ROR):  data_d = ror_dbl[DATA_W-1:0];
          INST_W'(OP_MAT): begin
            data_d  = col_w;
            rd_en   = 1'b1;
            state_d = ST_MOUT;
          end
          default:          data_d = '0;
        endcase
      end
      ST_OUT: state_d = ST_LOAD;
      ST_MOUT: begin
        // The final column is already on o_data when the read pointer runs off the end.
        if (mat_last) begin
          state_d = ST_LOAD;
          clr     = 1'b1;
        end else begin
          data_d = col_w;
          rd_en  = 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
    end
  end

  fx_mat_transpose #(
    .DATA_W(DATA_W),
    .MAT_N (MAT_N),
    .ELEM_W(ELEM_W)
  ) u_tr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .wr_en_i  (wr_en),
    .row_i    (bus.i_data_a),
    .clr_i    (clr),
    .rd_en_i  (rd_en),
    .row_cnt_o(row_cnt),
    .col_o    (col_w),
    .last_o   (mat_last)
  );

endmodule

// File: tb/tb_fx_alu_stream.sv
// Self-checking bench for fx_alu_stream: directed vector table, matrix/reset sequences, random scalar ops.
module tb_fx_alu_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fx_alu_stream_if #(.INST_W(4), .DATA_W(16)) bus ();

  fx_alu_stream #(
    .INST_W(4), .INT_W(6), .FRAC_W(10), .GUARD_W(4), .MAT_N(4)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int     n_chk = 0;
  int     n_fail = 0;
  longint m_acc = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic longint clampl(input longint v, input int w);
    longint hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference behaviour straight from the op definitions; m_acc is the model accumulator.
  function automatic logic [15:0] ref_op(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    longint      sa, sb;
    logic [15:0] r;
    int          n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (op)
      4'd0: r = 16'(clampl(sa + sb, 16));
      4'd1: r = 16'(clampl(sa - sb, 16));
      4'd2: begin
        m_acc = clampl(m_acc + sa * sb, 36);
        r     = 16'(clampl((m_acc + 512) >>> 10, 16));
      end
      4'd3: begin
        m_acc = 0;
        r     = '0;
      end
      4'd4: r = a ^ {1'b0, a[15:1]};
      4'd5: begin
        n = 0;
        while (n < 16 && a[15-n] == 1'b0) n++;
        r = 16'(n);
      end
      4'd6: begin
        r = a;
        for (int k = 0; k < int'(b[3:0]); k++) r = {r[0], r[15:1]};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] tcol(input logic [63:0] rows, input int j);
    logic [15:0] w;
    logic [15:0] row;
    w = '0;
    for (int r = 0; r < 4; r++) begin
      row = rows[63-16*r -: 16];
      w   = {w[11:0], row[15-4*j -: 4]};
    end
    return w;
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'($urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    chk("busy_before_accept", bus.o_busy, 0);
    bus.i_in_valid = 1'b1;
    bus.i_inst     = op;
    bus.i_data_a   = a;
    bus.i_data_b   = b;
    @(posedge clk);
    #1 bus.i_in_valid = 1'b0;
  endtask

  task automatic scalar(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp);
    send(op, a, b);
    @(negedge clk);
    chk("busy_T+1", bus.o_busy, 1);
    chk("ovld_T+1", bus.o_out_valid, 0);
    @(negedge clk);
    chk("busy_T+2", bus.o_busy, 1);
    chk("ovld_T+2", bus.o_out_valid, 1);
    chk($sformatf("data op%0d a=%h b=%h", op, a, b), bus.o_data, exp);
    @(negedge clk);
    chk("busy_T+3", bus.o_busy, 0);
    chk("ovld_T+3", bus.o_out_valid, 0);
    chk("data_hold", bus.o_data, exp);
  endtask

  task automatic mat_run(input logic [63:0] rows);
    for (int r = 0; r < 4; r++) begin
      send(4'd7, rows[63-16*r -: 16], 16'h0);
      if (r < 3) begin
        @(negedge clk);
        chk("mat_row_busy", bus.o_busy, 0);
        chk("mat_row_ovld", bus.o_out_valid, 0);
      end
    end
    @(negedge clk);
    chk("mat_busy_T+1", bus.o_busy, 1);
    chk("mat_ovld_T+1", bus.o_out_valid, 0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("mat_busy_stream", bus.o_busy, 1);
      chk("mat_ovld_stream", bus.o_out_valid, 1);
      chk($sformatf("mat_col%0d rows=%h", j, rows), bus.o_data, tcol(rows, j));
    end
    @(negedge clk);
    chk("mat_busy_end", bus.o_busy, 0);
    chk("mat_ovld_end", bus.o_out_valid, 0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] a, b;
    bus.i_in_valid = 1'b0;
    bus.i_inst     = '0;
    bus.i_data_a   = '0;
    bus.i_data_b   = '0;

    tbl[0]  = '{4'd0, 16'h7000, 16'h2000, 16'h7FFF};
    tbl[1]  = '{4'd1, 16'h8000, 16'h0001, 16'h8000};
    tbl[2]  = '{4'd0, 16'h0400, 16'hFC00, 16'h0000};
    tbl[3]  = '{4'd2, 16'h0400, 16'h0400, 16'h0400};
    tbl[4]  = '{4'd2, 16'h0400, 16'h0400, 16'h0800};
    tbl[5]  = '{4'd3, 16'h1111, 16'h2222, 16'h0000};
    tbl[6]  = '{4'd2, 16'h0001, 16'h0200, 16'h0001};
    tbl[7]  = '{4'd5, 16'h0000, 16'h0000, 16'h0010};
    tbl[8]  = '{4'd5, 16'h0001, 16'h0000, 16'h000F};
    tbl[9]  = '{4'd4, 16'h000F, 16'h0000, 16'h0008};
    tbl[10] = '{4'd6, 16'h0001, 16'h0001, 16'h8000};
    tbl[11] = '{4'd6, 16'h0001, 16'h0011, 16'h8000};
    tbl[12] = '{4'd9, 16'h1234, 16'h5678, 16'h0000};
    tbl[13] = '{4'd1, 16'h7FFF, 16'h8000, 16'h7FFF};
    tbl[14] = '{4'd6, 16'h1234, 16'h0004, 16'h4123};
    tbl[15] = '{4'd5, 16'h8000, 16'h0000, 16'h0000};
    tbl[16] = '{4'd15, 16'hFFFF, 16'hFFFF, 16'h0000};

    #1;
    chk("reset_busy", bus.o_busy, 0);
    chk("reset_ovld", bus.o_out_valid, 0);
    chk("reset_data", bus.o_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    foreach (tbl[i]) scalar(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);

    for (int i = 0; i < 20; i++) scalar(4'd2, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    scalar(4'd3, 16'h0000, 16'h0000, 16'h0000);
    m_acc = 0;

    // Input presented while busy must be ignored.
    send(4'd0, 16'h0100, 16'h0200);
    @(negedge clk);
    chk("ign_busy_T+1", bus.o_busy, 1);
    bus.i_in_valid = 1'b1;
    bus.i_inst     = 4'd1;
    bus.i_data_a   = 16'h7FFF;
    bus.i_data_b   = 16'h8000;
    @(negedge clk);
    chk("ign_ovld_T+2", bus.o_out_valid, 1);
    chk("ign_data", bus.o_data, 16'h0300);
    @(negedge clk);
    bus.i_in_valid = 1'b0;
    chk("ign_ovld_T+3", bus.o_out_valid, 0);
    repeat (3) begin
      @(negedge clk);
      chk("ign_no_strobe", bus.o_out_valid, 0);
      chk("ign_not_busy", bus.o_busy, 0);
    end

    mat_run(64'h123456789ABCDEF0);

    // Interrupted matrix: partial rows discarded, next matrix starts clean.
    send(4'd7, 16'h1234, 16'h0);
    send(4'd7, 16'h5678, 16'h0);
    scalar(4'd0, 16'h0001, 16'h0001, 16'h0002);
    mat_run(64'hFEDCBA9876543210);
    mat_run(64'h123456789ABCDEF0);
    repeat (4) mat_run({$urandom, $urandom});

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd7) op = 4'd2;
      a = pick();
      b = pick();
      scalar(op, a, b, ref_op(op, a, b));
    end

    // Reset during the transpose stream, after the second strobe.
    for (int r = 0; r < 4; r++) send(4'd7, 16'(64'h123456789ABCDEF0 >> (48 - 16*r)), 16'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_seq_col0", bus.o_data, 16'h159D);
    @(negedge clk);
    chk("rst_seq_col1", bus.o_data, 16'h26AE);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ovld", bus.o_out_valid, 0);
    chk("rst_async_busy", bus.o_busy, 0);
    chk("rst_async_data", bus.o_data, 0);
    @(negedge clk);
    chk("rst_hold_ovld", bus.o_out_valid, 0);
    rst_n = 1'b1;
    m_acc = 0;
    @(posedge clk);
    #1 chk("rst_after_ovld", bus.o_out_valid, 0);
    scalar(4'd2, 16'h0400, 16'h0400, ref_op(4'd2, 16'h0400, 16'h0400));
    scalar(4'd2, 16'h0400, 16'h0400, 16'h0800);
    mat_run(64'h0F1E2D3C4B5A6978);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
